// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-timing helper
// and the data width used by both uart_rx and uart_tx.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Whole clk cycles per serial bit; remainder is dropped.
  function automatic int baud_width(input int clock_speed,
                                    input int baud_rate);
    return clock_speed / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk, rst (async, active-high), d (async in), q (synchronized out).
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples start, data and stop bits.
// Ports: clk, rst (async, active-high), rx (serial in, idles high),
//   data (last good byte), rx_valid (1-cycle strobe on new data),
//   frame_err (1-cycle strobe on low stop bit), rx_busy (not IDLE).
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE   = 115_200,
  parameter int CLOCK_SPEED = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BAUD_WIDTH = baud_width(CLOCK_SPEED, BAUD_RATE);
  localparam int HALF_WIDTH = BAUD_WIDTH / 2;
  localparam int CNT_W      = $clog2(BAUD_WIDTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIDTH - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [7:0]           data_n;
  logic                 valid_n, ferr_n;

  uart_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      data      <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      data      <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          idx_n = '0;
          // High at start-bit centre means the edge was a glitch.
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BAUD_LAST) begin
          cnt_n        = '0;
          shift_n[idx] = rx_s;
          if (idx == IDX_LAST) state_n = STOP;
          else idx_n = idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BAUD_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      // Wait for the line to go idle so a held-low break
      // is not mistaken for a new start bit.
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1 MHz clk / 100 kbaud.
// Drives 8N1 frames from a behavioural line model and checks captured bytes.
module tb_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int BW     = CLK_HZ / BAUD;
  localparam int HW     = BW / 2;
  localparam int LAT    = 2 + 1 + HW + 9 * BW;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(
    .BAUD_RATE  (BAUD),
    .CLOCK_SPEED(CLK_HZ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  logic [7:0]  got_q[$];
  longint      got_t[$];
  int          ferr_cnt = 0;
  int          both_cnt = 0;
  bit          busy_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(data);
      got_t.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) both_cnt++;
    if (rx_busy) busy_seen = 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    tick(BW);
  endtask

  // Frame on the wire, LSB first: start(0), 8 data bits, stop.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(f[i]);
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_t.delete();
    ferr_cnt  = 0;
    busy_seen = 0;
  endtask

  function automatic logic [7:0] gq(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hxx;
  endfunction

  initial begin
    longint     t0;
    int         lat;
    int         n;
    logic [7:0] frm;
    logic [7:0] exp_q[$];
    int         bad;

    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    check("reset_data", data, 8'h00);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_ferr", frame_err, 1'b0);
    check("reset_busy", rx_busy, 1'b0);
    rst = 1'b0;
    tick(5);

    // Single frame with latency measurement
    clear_mon();
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    tick(10);
    check("a5_count", got_q.size(), 1);
    check("a5_data", gq(0), 8'hA5);
    check("a5_ferr", ferr_cnt, 0);
    check("a5_busy_seen", busy_seen, 1'b1);
    check("a5_busy_idle", rx_busy, 1'b0);
    lat = (got_t.size() > 0) ? int'(got_t[0] - t0) : -100;
    check("a5_latency", (lat >= LAT - 1 && lat <= LAT + 1), 1'b1);

    // Back-to-back, no idle gap
    clear_mon();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    tick(10);
    check("b2b_count", got_q.size(), 2);
    check("b2b_first", gq(0), 8'h00);
    check("b2b_second", gq(1), 8'hFF);
    n = (got_t.size() == 2) ? int'(got_t[1] - got_t[0]) : -100;
    check("b2b_spacing", (n >= 10 * BW - 1 && n <= 10 * BW + 1), 1'b1);
    check("b2b_data", data, 8'hFF);

    // Short low glitch
    clear_mon();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    n = 0;
    while (rx_busy && n < HW + 3) begin
      tick(1);
      n++;
    end
    check("glitch_busy_drop", rx_busy, 1'b0);
    tick(2 * BW);
    check("glitch_no_valid", got_q.size(), 0);
    check("glitch_no_ferr", ferr_cnt, 0);
    check("glitch_data", data, 8'hFF);

    // Stop bit low, then line held low
    clear_mon();
    frm = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(frm[i]);
    rx = 1'b0;
    tick(50);
    check("brk_ferr", ferr_cnt, 1);
    check("brk_no_valid", got_q.size(), 0);
    check("brk_data_kept", data, 8'hFF);
    check("brk_busy", rx_busy, 1'b1);
    rx = 1'b1;
    tick(BW);
    check("brk_release_idle", rx_busy, 1'b0);
    check("brk_no_retrigger", got_q.size(), 0);
    send_byte(8'h42, 1'b1);
    tick(10);
    check("after_brk_count", got_q.size(), 1);
    check("after_brk_data", data, 8'h42);
    check("after_brk_ferr", ferr_cnt, 1);

    // Reset during bit 4
    clear_mon();
    frm = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(frm[i]);
    rx = frm[4];
    tick(HW);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_data", data, 8'h00);
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_ferr", frame_err, 1'b0);
    check("midrst_busy", rx_busy, 1'b0);
    tick(3);
    rx  = 1'b1;
    rst = 1'b0;
    tick(2 * BW);
    check("midrst_no_pulse", got_q.size(), 0);
    check("midrst_no_ferr", ferr_cnt, 0);
    check("midrst_idle", rx_busy, 1'b0);
    send_byte(8'h81, 1'b1);
    tick(10);
    check("post_rst_count", got_q.size(), 1);
    check("post_rst_data", data, 8'h81);

    // All byte values with random idle gaps
    clear_mon();
    for (int b = 0; b < 256; b++) begin
      send_byte(8'(b), 1'b1);
      tick(int'($urandom_range(0, 3)));
    end
    tick(20);
    check("sweep_count", got_q.size(), 256);
    check("sweep_ferr", ferr_cnt, 0);
    bad = 0;
    for (int b = 0; b < 256; b++)
      if (gq(b) !== 8'(b)) bad++;
    check("sweep_bytes", bad, 0);

    // Random bytes with random gaps against a queue model
    clear_mon();
    exp_q.delete();
    for (int k = 0; k < 24; k++) begin
      frm = 8'($urandom);
      exp_q.push_back(frm);
      send_byte(frm, 1'b1);
      tick(int'($urandom_range(0, 2 * BW)));
    end
    tick(20);
    check("rand_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("rand_byte%0d", k), gq(k), exp_q[k]);
    check("rand_ferr", ferr_cnt, 0);
    check("rand_last_data", data, exp_q[exp_q.size() - 1]);

    check("valid_ferr_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Takes the asynchronous serial line, synchronizes it, and validates the start bit at mid-bit.
- Samples each data bit at its centre, checks the stop bit, then presents the byte with a single-cycle valid strobe.
- Pairs with uart_tx at the same BAUD_RATE/CLOCK_SPEED; sits between the pad and the host-side byte consumer.

Parameters:
- BAUD_RATE, 115_200, serial bit rate in bits/s.
- CLOCK_SPEED, 50_000_000, clk frequency in Hz.
- BAUD_WIDTH, CLOCK_SPEED/BAUD_RATE (434 at defaults), clk cycles per bit (derived, not overridden).
- HALF_WIDTH, BAUD_WIDTH/2 (217 at defaults), cycles from start-edge detect to start-bit centre check (derived).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  serial line, asynchronous to clk, idles high.
- data  output  8  last correctly framed byte; holds until the next good frame.
- rx_valid  output  1  one-cycle pulse when data is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: data=8'h00, rx_valid=0, frame_err=0, rx_busy=0, state=IDLE, counters=0, synchronizer flops=1.
- Reset mid-frame aborts the frame immediately; no valid or error pulse is produced.
- rx passes through a 2-flop synchronizer; rx_s is its output. All decisions use rx_s only.
- Bit counter width: $clog2(BAUD_WIDTH). Bit index: 3 bits.
- IDLE: rx_s==0 -> START, clear counter.
- START: count to HALF_WIDTH-1, then sample rx_s at the start-bit centre.
  - rx_s==1 -> IDLE (glitch reject, no pulse).
  - rx_s==0 -> DATA, clear counter and bit index.
- DATA: count to BAUD_WIDTH-1, then shift rx_s into shift register bit [index] (LSB first) and clear counter.
  - index==7 -> STOP; otherwise index+1.
- STOP: count to BAUD_WIDTH-1, then sample rx_s.
  - rx_s==1: data<=shift register, rx_valid=1 for exactly one cycle, -> IDLE.
  - rx_s==0: frame_err=1 for one cycle, data unchanged, -> BREAK.
- BREAK: stay until rx_s==1, then -> IDLE. A line held low (break) never re-triggers a frame.
- Counter behaviour: wraps only via explicit clear; never free-runs outside START/DATA/STOP.
- Back-to-back frames:
  - The new start bit may follow the stop-bit sample directly.
  - IDLE detects the falling edge within 1 cycle after return from STOP.
  - No idle time is required between frames.
- Latency, rx pin falling edge -> rx_valid: 2 (sync) + 1 (detect) + HALF_WIDTH + 9*BAUD_WIDTH cycles, within ±1.
  - Sampling points sit within ±1 cycle of each bit centre.
- rx_valid and frame_err are mutually exclusive and never asserted in consecutive cycles from the same frame.

Decomposition:
- Package uart_pkg holds:
  - rx state enum (IDLE, START, DATA, STOP, BREAK);
  - a function computing BAUD_WIDTH from CLOCK_SPEED/BAUD_RATE;
  - the DATA_BITS=8 constant, shared with uart_tx.
- Sub-module uart_sync: 2-flop synchronizer, reset value parameterised (1 here). Reusable for any async input.

Test Plan:
- For simulation set CLOCK_SPEED=1_000_000, BAUD_RATE=100_000, giving BAUD_WIDTH=10 and HALF_WIDTH=5.
- Single frame 8'hA5 with ideal bit timing -> one rx_valid pulse, data==8'hA5, frame_err stays 0, rx_busy high for the frame duration.
- Back-to-back 8'h00 then 8'hFF with zero idle gap -> two rx_valid pulses ~100 cycles apart; data==8'h00 then 8'hFF.
- rx low for 3 cycles then high (glitch) -> no rx_valid, no frame_err, rx_busy returns to 0 within HALF_WIDTH+3 cycles.
- Frame 8'h3C with stop bit driven low and line held low for 50 cycles -> one frame_err pulse, data keeps the previous value, no new frame until rx returns high.
  - A following good 8'h42 -> data==8'h42.
- Assert rst during bit 4 of a frame, release, then send 8'h81 -> no pulse for the aborted frame, outputs at reset values, then data==8'h81 with one rx_valid pulse.
- Loopback with uart_tx at default parameters, bytes 0x00..0xFF -> every byte received equal, 256 rx_valid pulses, zero frame_err.
